// File: rtl/alu_unit.sv
// ----------------------------------------------------------------------------
// alu_unit
//
// Integer execute unit sitting behind the reservation-station issue port.
// One decoded operation is accepted per cycle into a single exec stage.
// Its result is computed from the exec registers and written into a small
// result FIFO, which drains one entry per cycle onto the ALU channel of the
// common data bus.
//
// Ports
//   clk_in       system clock
//   rst_in       asynchronous active-high reset
//   rdy_in       global ready; low freezes every piece of state
//   _clear       synchronous flush (branch misprediction)
//   _alu_valid   issue strobe from the reservation station
//   _alu_type    5-bit operation code
//   _alu_rob_id  destination ROB entry
//   _alu_r1      operand 1 (PC for AUIPC / JAL / JALR)
//   _alu_r2      operand 2
//   _alu_imm     immediate
//   _alu_full    high: the reservation station must not issue
//   _cdb_busy    CDB arbiter denies the ALU channel this cycle
//   _cdb_ready   result valid on the CDB
//   _cdb_rob_id  result tag (0 when the FIFO is empty)
//   _cdb_value   result value (0 when the FIFO is empty)
// ----------------------------------------------------------------------------
module alu_unit #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _alu_valid,
    input  logic [4:0]       _alu_type,
    input  logic [ROB_W-1:0] _alu_rob_id,
    input  logic [31:0]      _alu_r1,
    input  logic [31:0]      _alu_r2,
    input  logic [31:0]      _alu_imm,
    output logic             _alu_full,
    input  logic             _cdb_busy,
    output logic             _cdb_ready,
    output logic [ROB_W-1:0] _cdb_rob_id,
    output logic [31:0]      _cdb_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] FULL_LVL = (CNT_W + 1)'(DEPTH);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_ADDI  = 5'd10;
    localparam logic [4:0] OP_ANDI  = 5'd11;
    localparam logic [4:0] OP_ORI   = 5'd12;
    localparam logic [4:0] OP_XORI  = 5'd13;
    localparam logic [4:0] OP_SLLI  = 5'd14;
    localparam logic [4:0] OP_SRLI  = 5'd15;
    localparam logic [4:0] OP_SRAI  = 5'd16;
    localparam logic [4:0] OP_SLTI  = 5'd17;
    localparam logic [4:0] OP_SLTIU = 5'd18;
    localparam logic [4:0] OP_LUI   = 5'd19;
    localparam logic [4:0] OP_AUIPC = 5'd20;
    localparam logic [4:0] OP_JAL   = 5'd21;
    localparam logic [4:0] OP_BEQ   = 5'd22;
    localparam logic [4:0] OP_BNE   = 5'd23;
    localparam logic [4:0] OP_BLT   = 5'd24;
    localparam logic [4:0] OP_BGE   = 5'd25;
    localparam logic [4:0] OP_BLTU  = 5'd26;
    localparam logic [4:0] OP_BGEU  = 5'd27;

    // Result of one operation. Register-register and immediate forms share
    // one datapath: the second operand is the immediate for codes 10..18.
    // Branch compares always use r1 against r2.
    function automatic logic [31:0] alu_calc(
        input logic [4:0]  op,
        input logic [31:0] a,
        input logic [31:0] r2,
        input logic [31:0] imm
    );
        logic [31:0]        b;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr2;
        logic [4:0]         sh;
        logic [31:0]        res;
        b   = (op >= OP_ADDI && op <= OP_SLTIU) ? imm : r2;
        sa  = a;
        sb  = b;
        sr2 = r2;
        sh  = b[4:0];
        res = '0;
        case (op)
            OP_ADD,  OP_ADDI:  res = a + b;
            OP_SUB:            res = a - b;
            OP_AND,  OP_ANDI:  res = a & b;
            OP_OR,   OP_ORI:   res = a | b;
            OP_XOR,  OP_XORI:  res = a ^ b;
            OP_SLL,  OP_SLLI:  res = a << sh;
            OP_SRL,  OP_SRLI:  res = a >> sh;
            OP_SRA,  OP_SRAI:  res = sa >>> sh;
            OP_SLT,  OP_SLTI:  res = {31'd0, (sa < sb)};
            OP_SLTU, OP_SLTIU: res = {31'd0, (a < b)};
            OP_LUI:            res = imm;
            OP_AUIPC:          res = a + imm;
            OP_JAL:            res = a + 32'd4;
            OP_BEQ:            res = {31'd0, (a == r2)};
            OP_BNE:            res = {31'd0, (a != r2)};
            OP_BLT:            res = {31'd0, (sa < sr2)};
            OP_BGE:            res = {31'd0, (sa >= sr2)};
            OP_BLTU:           res = {31'd0, (a < r2)};
            OP_BGEU:           res = {31'd0, (a >= r2)};
            default:           res = '0;
        endcase
        return res;
    endfunction

    logic             vld_p1;
    logic [4:0]       op_p1;
    logic [ROB_W-1:0] rob_p1;
    logic [31:0]      r1_p1;
    logic [31:0]      r2_p1;
    logic [31:0]      imm_p1;
    logic [31:0]      res_p1;

    logic [ROB_W-1:0] fifo_rob_p2 [DEPTH];
    logic [31:0]      fifo_val_p2 [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             issue_ok;
    logic             push;
    logic             pop;
    logic             empty;
    logic [CNT_W:0]   occupancy;

    // An issue against a full unit is a protocol violation and is dropped.
    assign issue_ok = _alu_valid && rdy_in && !_clear && !_alu_full;
    assign push     = vld_p1 && rdy_in && !_clear;
    assign pop      = _cdb_ready;
    assign empty    = (count == '0);

    // Counting the exec stage as occupied reserves a slot for the result
    // already in flight, so a push never finds the FIFO full.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
    assign _alu_full = (occupancy >= FULL_LVL);

    // ---- stage p1: exec registers ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p1 <= 1'b0;
        end else if (rdy_in) begin
            vld_p1 <= issue_ok;
        end
    end

    always_ff @(posedge clk_in) begin
        if (issue_ok) begin
            op_p1  <= _alu_type;
            rob_p1 <= _alu_rob_id;
            r1_p1  <= _alu_r1;
            r2_p1  <= _alu_r2;
            imm_p1 <= _alu_imm;
        end
    end

    always_comb begin
        res_p1 = alu_calc(op_p1, r1_p1, r2_p1, imm_p1);
    end

    // ---- stage p2: result FIFO ----
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_rob_p2[tail] <= rob_p1;
            fifo_val_p2[tail] <= res_p1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // ---- CDB broadcast from FIFO head ----
    // Gating with _clear keeps the flush cycle silent; the next cycle is
    // silent because the FIFO has just been emptied.
    assign _cdb_ready  = !empty && !_cdb_busy && rdy_in && !_clear;
    assign _cdb_rob_id = empty ? '0 : fifo_rob_p2[head];
    assign _cdb_value  = empty ? '0 : fifo_val_p2[head];

endmodule

// File: tb/tb_alu_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_unit
//
// Directed bench for alu_unit. Inputs change just after the falling edge,
// outputs are sampled 1 time unit later, and the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_alu_unit;

    localparam int DEPTH = 4;
    localparam int ROB_W = 5;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             _clear;
    logic             _alu_valid;
    logic [4:0]       _alu_type;
    logic [ROB_W-1:0] _alu_rob_id;
    logic [31:0]      _alu_r1;
    logic [31:0]      _alu_r2;
    logic [31:0]      _alu_imm;
    logic             _alu_full;
    logic             _cdb_busy;
    logic             _cdb_ready;
    logic [ROB_W-1:0] _cdb_rob_id;
    logic [31:0]      _cdb_value;

    int n_chk = 0;
    int n_err = 0;

    alu_unit #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._alu_valid  (_alu_valid),
        ._alu_type   (_alu_type),
        ._alu_rob_id (_alu_rob_id),
        ._alu_r1     (_alu_r1),
        ._alu_r2     (_alu_r2),
        ._alu_imm    (_alu_imm),
        ._alu_full   (_alu_full),
        ._cdb_busy   (_cdb_busy),
        ._cdb_ready  (_cdb_ready),
        ._cdb_rob_id (_cdb_rob_id),
        ._cdb_value  (_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_issue(input logic [4:0] op, input int rob,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] imm);
        _alu_valid  = 1'b1;
        _alu_type   = op;
        _alu_rob_id = ROB_W'(rob);
        _alu_r1     = r1;
        _alu_r2     = r2;
        _alu_imm    = imm;
    endtask

    task automatic drive_idle();
        _alu_valid = 1'b0;
    endtask

    task automatic next_cyc();
        @(negedge clk_in);
    endtask

    // Single isolated operation: issue, one silent cycle, then one broadcast.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [31:0] exp);
        next_cyc();
        drive_issue(op, 7, r1, r2, imm);
        #1;
        next_cyc();
        drive_idle();
        #1;
        chk_eq({tag, "_early"}, 32'(_cdb_ready), 32'd0);
        next_cyc();
        #1;
        chk_eq({tag, "_rdy"}, 32'(_cdb_ready), 32'd1);
        chk_eq({tag, "_rob"}, 32'(_cdb_rob_id), 32'd7);
        chk_eq({tag, "_val"}, _cdb_value, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        _clear      = 1'b0;
        _alu_valid  = 1'b0;
        _alu_type   = 5'd0;
        _alu_rob_id = '0;
        _alu_r1     = '0;
        _alu_r2     = '0;
        _alu_imm    = '0;
        _cdb_busy   = 1'b0;

        // Reset state
        #1;
        chk_eq("rst_ready", 32'(_cdb_ready), 32'd0);
        chk_eq("rst_rob", 32'(_cdb_rob_id), 32'd0);
        chk_eq("rst_val", _cdb_value, 32'd0);
        chk_eq("rst_full", 32'(_alu_full), 32'd0);
        next_cyc();
        next_cyc();
        rst_in = 1'b0;
        #1;

        // ADD latency: visible exactly two cycles after issue, for one cycle
        next_cyc();
        drive_issue(5'd0, 3, 32'd5, 32'd7, 32'd0);
        #1;
        chk_eq("lat_c0", 32'(_cdb_ready), 32'd0);
        next_cyc();
        drive_idle();
        #1;
        chk_eq("lat_c1", 32'(_cdb_ready), 32'd0);
        next_cyc();
        #1;
        chk_eq("lat_c2_rdy", 32'(_cdb_ready), 32'd1);
        chk_eq("lat_c2_rob", 32'(_cdb_rob_id), 32'd3);
        chk_eq("lat_c2_val", _cdb_value, 32'd12);
        next_cyc();
        #1;
        chk_eq("lat_c3_rdy", 32'(_cdb_ready), 32'd0);
        chk_eq("lat_c3_rob", 32'(_cdb_rob_id), 32'd0);
        chk_eq("lat_c3_val", _cdb_value, 32'd0);

        // Opcode coverage
        run_op("sub",      5'd1,  32'd0,        32'd1,        32'd0,        32'hFFFFFFFF);
        run_op("srai",     5'd16, 32'h80000000, 32'd0,        32'd4,        32'hF8000000);
        run_op("sltu",     5'd9,  32'd1,        32'hFFFFFFFF, 32'd0,        32'd1);
        run_op("slt",      5'd8,  32'd1,        32'hFFFFFFFF, 32'd0,        32'd0);
        run_op("sll_sh5",  5'd5,  32'd1,        32'h21,       32'd0,        32'd2);
        run_op("srl",      5'd6,  32'h80000000, 32'd31,       32'd0,        32'd1);
        run_op("and",      5'd2,  32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000F000);
        run_op("xori",     5'd13, 32'hFF,       32'h55,       32'h0F,       32'hF0);
        run_op("addi",     5'd10, 32'd100,      32'h999,      32'hFFFFFFFF, 32'd99);
        run_op("slti",     5'd17, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFD, 32'd1);
        run_op("lui",      5'd19, 32'd1,        32'd2,        32'h12345000, 32'h12345000);
        run_op("auipc",    5'd20, 32'h1000,     32'd7,        32'h20,       32'h1020);
        run_op("jal",      5'd21, 32'h100,      32'd7,        32'd9,        32'h104);
        run_op("beq",      5'd22, 32'd9,        32'd9,        32'd0,        32'd1);
        run_op("blt",      5'd24, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1);
        run_op("bge",      5'd25, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0);
        run_op("bltu",     5'd26, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0);
        run_op("op30",     5'd30, 32'd5,        32'd6,        32'd7,        32'd0);

        // Backpressure: busy held, five back-to-back issues
        next_cyc();
        _cdb_busy = 1'b1;
        drive_issue(5'd0, 0, 32'd0, 32'd0, 32'd0);
        #1;
        chk_eq("full_i0", 32'(_alu_full), 32'd0);
        for (int i = 1; i < 4; i++) begin
            next_cyc();
            drive_issue(5'd0, i, 32'(i), 32'd0, 32'd0);
            #1;
            chk_eq("full_low", 32'(_alu_full), 32'd0);
        end
        next_cyc();
        drive_issue(5'd0, 4, 32'd4, 32'd0, 32'd0);
        #1;
        chk_eq("full_set", 32'(_alu_full), 32'd1);
        next_cyc();
        drive_idle();
        #1;
        chk_eq("full_hold", 32'(_alu_full), 32'd1);
        chk_eq("full_busy_rdy", 32'(_cdb_ready), 32'd0);
        next_cyc();
        _cdb_busy = 1'b0;
        #1;
        chk_eq("drain0_rdy", 32'(_cdb_ready), 32'd1);
        chk_eq("drain0_rob", 32'(_cdb_rob_id), 32'd0);
        chk_eq("drain0_full", 32'(_alu_full), 32'd1);
        for (int i = 1; i < 4; i++) begin
            next_cyc();
            #1;
            chk_eq("drain_rdy", 32'(_cdb_ready), 32'd1);
            chk_eq("drain_rob", 32'(_cdb_rob_id), 32'(i));
            chk_eq("drain_val", _cdb_value, 32'(i));
            chk_eq("drain_full", 32'(_alu_full), 32'd0);
        end
        next_cyc();
        #1;
        chk_eq("full_rob4_dropped", 32'(_cdb_ready), 32'd0);

        // Continuous stream through wrapping pointers
        next_cyc();
        _cdb_busy = 1'b1;
        drive_issue(5'd0, 10, 32'd30, 32'd1000, 32'd0);
        next_cyc();
        drive_issue(5'd0, 11, 32'd33, 32'd1000, 32'd0);
        next_cyc();
        drive_issue(5'd0, 12, 32'd36, 32'd1000, 32'd0);
        next_cyc();
        drive_idle();
        for (int i = 0; i < 11; i++) begin
            next_cyc();
            _cdb_busy = 1'b0;
            if (i < 2 * DEPTH) begin
                drive_issue(5'd0, 13 + i, 32'((13 + i) * 3), 32'd1000, 32'd0);
            end else begin
                drive_idle();
            end
            #1;
            chk_eq("wrap_rdy", 32'(_cdb_ready), 32'd1);
            chk_eq("wrap_rob", 32'(_cdb_rob_id), 32'(10 + i));
            chk_eq("wrap_val", _cdb_value, 32'((10 + i) * 3 + 1000));
            chk_eq("wrap_full", 32'(_alu_full), 32'd0);
        end
        next_cyc();
        drive_idle();
        #1;
        chk_eq("wrap_drained", 32'(_cdb_ready), 32'd0);

        // Flush with two buffered, one in exec and a concurrent issue
        next_cyc();
        _cdb_busy = 1'b1;
        drive_issue(5'd0, 1, 32'd1, 32'd1, 32'd0);
        next_cyc();
        drive_issue(5'd0, 2, 32'd2, 32'd1, 32'd0);
        next_cyc();
        drive_issue(5'd0, 3, 32'd3, 32'd1, 32'd0);
        next_cyc();
        _clear    = 1'b1;
        _cdb_busy = 1'b0;
        drive_issue(5'd0, 9, 32'd9, 32'd1, 32'd0);
        #1;
        chk_eq("clr_c0_rdy", 32'(_cdb_ready), 32'd0);
        chk_eq("clr_c0_head", 32'(_cdb_rob_id), 32'd1);
        next_cyc();
        _clear = 1'b0;
        drive_idle();
        #1;
        chk_eq("clr_c1_rdy", 32'(_cdb_ready), 32'd0);
        chk_eq("clr_c1_rob", 32'(_cdb_rob_id), 32'd0);
        chk_eq("clr_c1_full", 32'(_alu_full), 32'd0);
        next_cyc();
        #1;
        chk_eq("clr_c2_rdy", 32'(_cdb_ready), 32'd0);
        next_cyc();
        drive_issue(5'd0, 5, 32'd40, 32'd2, 32'd0);
        #1;
        chk_eq("clr_post_c0", 32'(_cdb_ready), 32'd0);
        next_cyc();
        drive_idle();
        #1;
        chk_eq("clr_post_c1", 32'(_cdb_ready), 32'd0);
        next_cyc();
        #1;
        chk_eq("clr_post_rdy", 32'(_cdb_ready), 32'd1);
        chk_eq("clr_post_rob", 32'(_cdb_rob_id), 32'd5);
        chk_eq("clr_post_val", _cdb_value, 32'd42);
        next_cyc();
        #1;
        chk_eq("clr_post_empty", 32'(_cdb_ready), 32'd0);

        // rdy_in low freezes everything
        next_cyc();
        _cdb_busy = 1'b1;
        drive_issue(5'd0, 6, 32'd60, 32'd0, 32'd0);
        next_cyc();
        drive_issue(5'd0, 7, 32'd70, 32'd0, 32'd0);
        next_cyc();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            rdy_in    = 1'b0;
            _cdb_busy = 1'b0;
            drive_issue(5'd0, 8, 32'd80, 32'd0, 32'd0);
            #1;
            chk_eq("frz_rdy", 32'(_cdb_ready), 32'd0);
            chk_eq("frz_full", 32'(_alu_full), 32'd0);
            chk_eq("frz_head", 32'(_cdb_rob_id), 32'd6);
        end
        next_cyc();
        rdy_in = 1'b1;
        drive_idle();
        #1;
        chk_eq("thaw0_rdy", 32'(_cdb_ready), 32'd1);
        chk_eq("thaw0_rob", 32'(_cdb_rob_id), 32'd6);
        chk_eq("thaw0_val", _cdb_value, 32'd60);
        next_cyc();
        #1;
        chk_eq("thaw1_rdy", 32'(_cdb_ready), 32'd1);
        chk_eq("thaw1_rob", 32'(_cdb_rob_id), 32'd7);
        chk_eq("thaw1_val", _cdb_value, 32'd70);
        next_cyc();
        #1;
        chk_eq("thaw_rob8_dropped", 32'(_cdb_ready), 32'd0);

        // Asynchronous reset in the middle of a broadcast
        next_cyc();
        _cdb_busy = 1'b1;
        drive_issue(5'd0, 11, 32'd5, 32'd5, 32'd0);
        next_cyc();
        drive_issue(5'd0, 12, 32'd6, 32'd6, 32'd0);
        next_cyc();
        drive_idle();
        _cdb_busy = 1'b0;
        #1;
        chk_eq("arst_pre_rdy", 32'(_cdb_ready), 32'd1);
        chk_eq("arst_pre_val", _cdb_value, 32'd10);
        #2;
        rst_in = 1'b1;
        #1;
        chk_eq("arst_rdy", 32'(_cdb_ready), 32'd0);
        chk_eq("arst_rob", 32'(_cdb_rob_id), 32'd0);
        chk_eq("arst_val", _cdb_value, 32'd0);
        chk_eq("arst_full", 32'(_alu_full), 32'd0);
        next_cyc();
        rst_in = 1'b0;
        #1;
        chk_eq("arst_c1_rdy", 32'(_cdb_ready), 32'd0);
        next_cyc();
        #1;
        chk_eq("arst_c2_rdy", 32'(_cdb_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
